xtal_osc_ctrl: RTL



---
 rtl/xtal_osc_ctrl_pkg.sv | 30 +++
 rtl/xtal_edge_sync.sv | 30 +++
 rtl/xtal_osc_ctrl.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/xtal_osc_ctrl_pkg.sv
// Shared state encoding and default 50 MHz clk / 16 MHz crystal timing for the oscillator controller.
// Optional feature macro XTAL_OSC_CTRL_AUTORETRY_EN adds the RETRY cooldown state.
package xtal_osc_ctrl_pkg;

  localparam int EDGE_W             = 8;
  localparam int DEF_STARTUP_CYCLES = 65536;
  localparam int DEF_WIN_CYCLES     = 256;
  localparam int DEF_MIN_EDGES      = 76;
  localparam int DEF_MAX_EDGES      = 88;
  localparam int DEF_LOSS_CYCLES    = 8;
  localparam int DEF_RETRY_MAX      = 3;
  localparam int RETRY_COOL_CYCLES  = 16;

  typedef enum logic [2:0] {
    ST_OFF,
    ST_STARTUP,
    ST_MEASURE,
    ST_RUN,
    ST_STANDBY,
    ST_FAIL
`ifdef XTAL_OSC_CTRL_AUTORETRY_EN
    , ST_RETRY
`endif
  } state_e;

  function automatic logic [EDGE_W-1:0] sat_inc(input logic [EDGE_W-1:0] v, input logic inc);
    return (inc && (v != {EDGE_W{1'b1}})) ? v + 1'b1 : v;
  endfunction

endpackage

// File: rtl/xtal_edge_sync.sv
// Two-flop synchronizer for the free-running crystal output plus a rising-edge pulse.
// Latency: a pin edge appears as a one-cycle pulse 2-3 clk cycles later; no backpressure.
module xtal_edge_sync
  import xtal_osc_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= i_async;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_rise = r_s2 & ~r_s3;

endmodule

// File: rtl/xtal_osc_ctrl.sv
// Crystal oscillator sequencer: startup wait, edge-count frequency qualification, clock-loss watch.
// Latency: outputs registered one cycle after the deciding event; no backpressure. Option: XTAL_OSC_CTRL_AUTORETRY_EN.
module xtal_osc_ctrl
  import xtal_osc_ctrl_pkg::*;
#(
  parameter int STARTUP_CYCLES = DEF_STARTUP_CYCLES,
  parameter int WIN_CYCLES     = DEF_WIN_CYCLES,
  parameter int MIN_EDGES      = DEF_MIN_EDGES,
  parameter int MAX_EDGES      = DEF_MAX_EDGES,
  parameter int LOSS_CYCLES    = DEF_LOSS_CYCLES
`ifdef XTAL_OSC_CTRL_AUTORETRY_EN
  , parameter int RETRY_MAX    = DEF_RETRY_MAX
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_en,
  input  logic              req_stdby,
  input  logic              xtal_dout,
  output logic              osc_ena,
  output logic              osc_stdby,
  output logic              xtal_ready,
  output logic              xtal_fail,
  output logic [EDGE_W-1:0] edge_count
);

  localparam int CNT_MAX0 = (STARTUP_CYCLES > WIN_CYCLES) ? STARTUP_CYCLES : WIN_CYCLES;
  localparam int CNT_MAX  = (CNT_MAX0 > RETRY_COOL_CYCLES) ? CNT_MAX0 : RETRY_COOL_CYCLES;
  localparam int CNT_W    = $clog2(CNT_MAX + 1);
  localparam int LOSS_W   = $clog2(LOSS_CYCLES + 1);
  localparam logic [CNT_W-1:0]  STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
  localparam logic [CNT_W-1:0]  WIN_LAST     = CNT_W'(WIN_CYCLES - 1);
  localparam logic [LOSS_W-1:0] LOSS_LAST    = LOSS_W'(LOSS_CYCLES - 1);

  state_e              r_state;
  state_e              w_state_nxt;
  state_e              w_fail_dst;
  logic [CNT_W-1:0]    r_cnt;
  logic [CNT_W-1:0]    w_cnt_nxt;
  logic [EDGE_W-1:0]   r_edges;
  logic [EDGE_W-1:0]   w_edges_nxt;
  logic [EDGE_W-1:0]   w_edges_inc;
  logic [LOSS_W-1:0]   r_loss;
  logic [LOSS_W-1:0]   w_loss_nxt;
  logic                w_rise;
  logic                w_in_range;
  logic                w_loss_hit;
  logic                w_edge_load;
  logic                r_osc_ena;
  logic                r_osc_stdby;
  logic                r_ready;
  logic                r_fail;
  logic [EDGE_W-1:0]   r_edge_count;

  xtal_edge_sync u_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (xtal_dout),
    .o_rise  (w_rise)
  );

  // Count includes a pulse landing in the final window cycle.
  assign w_edges_inc = sat_inc(r_edges, w_rise);
  assign w_in_range  = (w_edges_inc >= EDGE_W'(MIN_EDGES)) && (w_edges_inc <= EDGE_W'(MAX_EDGES));
  assign w_loss_hit  = (r_state == ST_RUN) && !w_rise && (r_loss == LOSS_LAST);

`ifdef XTAL_OSC_CTRL_AUTORETRY_EN
  localparam int RETRY_W = $clog2(RETRY_MAX + 2);
  localparam logic [CNT_W-1:0] COOL_LAST = CNT_W'(RETRY_COOL_CYCLES - 1);
  logic [RETRY_W-1:0] r_retry;

  assign w_fail_dst = (r_retry < RETRY_W'(RETRY_MAX)) ? ST_RETRY : ST_FAIL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_retry <= '0;
    end else if (!req_en || (w_state_nxt == ST_RUN)) begin
      r_retry <= '0;
    end else if ((r_state == ST_RETRY) && (w_state_nxt == ST_STARTUP)) begin
      r_retry <= r_retry + 1'b1;
    end
  end
`else
  assign w_fail_dst = ST_FAIL;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_edges_nxt = r_edges;
    w_loss_nxt  = '0;
    w_edge_load = 1'b0;
    case (r_state)
      ST_OFF: begin
        w_cnt_nxt = '0;
        if (req_en) w_state_nxt = ST_STARTUP;
      end
      ST_STARTUP: begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_edges_nxt = '0;
        if (r_cnt == STARTUP_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        w_cnt_nxt   = r_cnt + 1'b1;
        w_edges_nxt = w_edges_inc;
        if (r_cnt == WIN_LAST) begin
          w_cnt_nxt   = '0;
          w_edges_nxt = '0;
          w_edge_load = 1'b1;
          w_state_nxt = w_in_range ? ST_RUN : w_fail_dst;
        end
      end
      ST_RUN: begin
        w_loss_nxt = w_rise ? '0 : r_loss + 1'b1;
        // A dying crystal is reported even if standby is requested in the same cycle.
        if (w_loss_hit)     w_state_nxt = w_fail_dst;
        else if (req_stdby) w_state_nxt = ST_STANDBY;
      end
      ST_STANDBY: begin
        w_cnt_nxt   = '0;
        w_edges_nxt = '0;
        if (!req_stdby) w_state_nxt = ST_MEASURE;
      end
      ST_FAIL: begin
        w_state_nxt = ST_FAIL;
      end
`ifdef XTAL_OSC_CTRL_AUTORETRY_EN
      ST_RETRY: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == COOL_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = ST_STARTUP;
        end
      end
`endif
      default: begin
        w_state_nxt = ST_OFF;
      end
    endcase
    if (!req_en) begin
      w_state_nxt = ST_OFF;
      w_cnt_nxt   = '0;
      w_edges_nxt = '0;
      w_loss_nxt  = '0;
      w_edge_load = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_OFF;
      r_cnt        <= '0;
      r_edges      <= '0;
      r_loss       <= '0;
      r_osc_ena    <= 1'b0;
      r_osc_stdby  <= 1'b0;
      r_ready      <= 1'b0;
      r_fail       <= 1'b0;
      r_edge_count <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_edges     <= w_edges_nxt;
      r_loss      <= w_loss_nxt;
      r_osc_ena   <= (w_state_nxt inside {ST_STARTUP, ST_MEASURE, ST_RUN, ST_STANDBY});
      r_osc_stdby <= (w_state_nxt == ST_STANDBY);
      r_ready     <= (w_state_nxt == ST_RUN);
      r_fail      <= (w_state_nxt == ST_FAIL);
      if (w_edge_load) r_edge_count <= w_edges_inc;
    end
  end

  assign osc_ena    = r_osc_ena;
  assign osc_stdby  = r_osc_stdby;
  assign xtal_ready = r_ready;
  assign xtal_fail  = r_fail;
  assign edge_count = r_edge_count;

endmodule
